// File: rtl/caxi4interconnect_txn_limiter_pkg.sv
`default_nettype none
// ============================================================================
// caxi4interconnect_txn_limiter_pkg
// Shared drain-FSM state type and outstanding-counter update helper.
// Revision: 1.0
// ============================================================================
package caxi4interconnect_txn_limiter_pkg;

  localparam int CNT_CALC_W = 8;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } limiter_state_e;

  typedef struct packed {
    logic [CNT_CALC_W-1:0] cnt;
    logic                  underflow;
  } cnt_upd_t;

  // A retire against an empty counter pins it at zero even if an issue
  // lands in the same cycle; the caller flags the protocol error.
  function automatic cnt_upd_t cnt_next(input logic                  issue,
                                        input logic                  retire,
                                        input logic [CNT_CALC_W-1:0] count);
    cnt_upd_t r;
    r.cnt       = count;
    r.underflow = 1'b0;
    if (retire && (count == '0)) begin
      r.underflow = 1'b1;
    end else if (issue && !retire) begin
      r.cnt = count + CNT_CALC_W'(1);
    end else if (retire && !issue) begin
      r.cnt = count - CNT_CALC_W'(1);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/caxi4interconnect_txn_counter.sv
`default_nettype none
// ============================================================================
// caxi4interconnect_txn_counter
// One channel's issue gating, outstanding counter and underflow detect.
// Optional peak tracking with CAXI4_TXN_LIMIT_PEAK_EN.
// Revision: 1.0
// ============================================================================
module caxi4interconnect_txn_counter
  import caxi4interconnect_txn_limiter_pkg::*;
#(
  parameter int  MAX   = 8,
  localparam int CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_block,
  input  logic             up_valid,
  output logic             up_ready,
  output logic             dn_valid,
  input  logic             dn_ready,
  input  logic             retire,
  output logic [CNT_W-1:0] count,
  output logic             underflow
`ifdef CAXI4_TXN_LIMIT_PEAK_EN
  ,
  input  logic             peak_clr,
  output logic [CNT_W-1:0] peak
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX);

  logic [CNT_W-1:0] count_q, count_d;
  logic             block;
  logic             issue;
  cnt_upd_t         upd;

  assign block    = (count_q == MAX_CNT) | ext_block;
  assign dn_valid = up_valid & ~block;
  assign up_ready = dn_ready & ~block;
  assign issue    = dn_valid & dn_ready;

  always_comb begin
    upd       = cnt_next(issue, retire, CNT_CALC_W'(count_q));
    count_d   = CNT_W'(upd.cnt);
    underflow = upd.underflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

`ifdef CAXI4_TXN_LIMIT_PEAK_EN
  logic [CNT_W-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (peak_clr)              peak_d = '0;
    else if (count_d > peak_q) peak_d = count_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign peak = peak_q;
`endif

endmodule
`default_nettype wire

// File: rtl/caxi4interconnect_mstr_txn_limiter.sv
`default_nettype none
// ============================================================================
// caxi4interconnect_mstr_txn_limiter
// Per-master outstanding AR/AW limiter with drain handshake and sticky
// protocol-error flag. Peak counters enabled by CAXI4_TXN_LIMIT_PEAK_EN.
// Revision: 1.0
// ============================================================================
module caxi4interconnect_mstr_txn_limiter
  import caxi4interconnect_txn_limiter_pkg::*;
#(
  parameter int  MAX_RD_OUTSTANDING = 8,
  parameter int  MAX_WR_OUTSTANDING = 8,
  localparam int RD_CNT_W = $clog2(MAX_RD_OUTSTANDING + 1),
  localparam int WR_CNT_W = $clog2(MAX_WR_OUTSTANDING + 1)
) (
  input  logic                XBAR_CLK,
  input  logic                sysReset,
  input  logic                up_ARVALID,
  output logic                up_ARREADY,
  output logic                dn_ARVALID,
  input  logic                dn_ARREADY,
  input  logic                up_AWVALID,
  output logic                up_AWREADY,
  output logic                dn_AWVALID,
  input  logic                dn_AWREADY,
  input  logic                RVALID,
  input  logic                RREADY,
  input  logic                RLAST,
  input  logic                BVALID,
  input  logic                BREADY,
  input  logic                drainReq,
  output logic                drainDone,
  output logic [RD_CNT_W-1:0] rdCount,
  output logic [WR_CNT_W-1:0] wrCount,
  output logic                protErr
`ifdef CAXI4_TXN_LIMIT_PEAK_EN
  ,
  input  logic                peakClr,
  output logic [RD_CNT_W-1:0] rdPeak,
  output logic [WR_CNT_W-1:0] wrPeak
`endif
);

  limiter_state_e state_q, state_d;
  logic           drain_done_q, drain_done_d;
  logic           prot_err_q, prot_err_d;
  logic           issue_block;
  logic           rd_uf, wr_uf;

  assign issue_block = (state_q != ST_RUN);

  caxi4interconnect_txn_counter #(.MAX(MAX_RD_OUTSTANDING)) u_rd_cnt (
    .clk       (XBAR_CLK),
    .rst       (sysReset),
    .ext_block (issue_block),
    .up_valid  (up_ARVALID),
    .up_ready  (up_ARREADY),
    .dn_valid  (dn_ARVALID),
    .dn_ready  (dn_ARREADY),
    .retire    (RVALID & RREADY & RLAST),
    .count     (rdCount),
    .underflow (rd_uf)
`ifdef CAXI4_TXN_LIMIT_PEAK_EN
    ,
    .peak_clr  (peakClr),
    .peak      (rdPeak)
`endif
  );

  caxi4interconnect_txn_counter #(.MAX(MAX_WR_OUTSTANDING)) u_wr_cnt (
    .clk       (XBAR_CLK),
    .rst       (sysReset),
    .ext_block (issue_block),
    .up_valid  (up_AWVALID),
    .up_ready  (up_AWREADY),
    .dn_valid  (dn_AWVALID),
    .dn_ready  (dn_AWREADY),
    .retire    (BVALID & BREADY),
    .count     (wrCount),
    .underflow (wr_uf)
`ifdef CAXI4_TXN_LIMIT_PEAK_EN
    ,
    .peak_clr  (peakClr),
    .peak      (wrPeak)
`endif
  );

  always_comb begin
    state_d    = state_q;
    prot_err_d = prot_err_q | rd_uf | wr_uf;
    case (state_q)
      ST_RUN:     if (drainReq) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!drainReq)                                state_d = ST_RUN;
        else if ((rdCount == '0) && (wrCount == '0))  state_d = ST_DRAINED;
      end
      ST_DRAINED: if (!drainReq) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
    // Lags DRAINED entry by one cycle but drops together with the exit.
    drain_done_d = (state_q == ST_DRAINED) && (state_d == ST_DRAINED);
  end

  always_ff @(posedge XBAR_CLK or posedge sysReset) begin
    if (sysReset) begin
      state_q      <= ST_RUN;
      drain_done_q <= 1'b0;
      prot_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_done_q <= drain_done_d;
      prot_err_q   <= prot_err_d;
    end
  end

  assign drainDone = drain_done_q;
  assign protErr   = prot_err_q;

endmodule
`default_nettype wire

// File: tb/tb_caxi4interconnect_mstr_txn_limiter.sv
`default_nettype none
// ============================================================================
// tb_caxi4interconnect_mstr_txn_limiter
// Scoreboard bench: stimulus queues expected values, negedge monitor checks.
// Revision: 1.0
// ============================================================================
module tb_caxi4interconnect_mstr_txn_limiter;

  localparam int S_RD  = 0;
  localparam int S_WR  = 1;
  localparam int S_PE  = 2;
  localparam int S_DD  = 3;
  localparam int S_UAR = 4;
  localparam int S_DAR = 5;
  localparam int S_UAW = 6;
  localparam int S_DAW = 7;
  localparam int S_RDP = 8;
  localparam int S_WRP = 9;

  logic       clk;
  logic       sysReset;
  logic       up_ARVALID, up_ARREADY, dn_ARVALID, dn_ARREADY;
  logic       up_AWVALID, up_AWREADY, dn_AWVALID, dn_AWREADY;
  logic       RVALID, RREADY, RLAST, BVALID, BREADY;
  logic       drainReq, drainDone, protErr;
  logic [1:0] rdCount;
  logic [2:0] wrCount;
`ifdef CAXI4_TXN_LIMIT_PEAK_EN
  logic       peakClr;
  logic [1:0] rdPeak;
  logic [2:0] wrPeak;
`endif

  caxi4interconnect_mstr_txn_limiter #(
    .MAX_RD_OUTSTANDING (2),
    .MAX_WR_OUTSTANDING (6)
  ) dut (
    .XBAR_CLK   (clk),
    .sysReset   (sysReset),
    .up_ARVALID (up_ARVALID),
    .up_ARREADY (up_ARREADY),
    .dn_ARVALID (dn_ARVALID),
    .dn_ARREADY (dn_ARREADY),
    .up_AWVALID (up_AWVALID),
    .up_AWREADY (up_AWREADY),
    .dn_AWVALID (dn_AWVALID),
    .dn_AWREADY (dn_AWREADY),
    .RVALID     (RVALID),
    .RREADY     (RREADY),
    .RLAST      (RLAST),
    .BVALID     (BVALID),
    .BREADY     (BREADY),
    .drainReq   (drainReq),
    .drainDone  (drainDone),
    .rdCount    (rdCount),
    .wrCount    (wrCount),
    .protErr    (protErr)
`ifdef CAXI4_TXN_LIMIT_PEAK_EN
    ,
    .peakClr    (peakClr),
    .rdPeak     (rdPeak),
    .wrPeak     (wrPeak)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    sig;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic int sample(input int sig);
    case (sig)
      S_RD:  return int'(rdCount);
      S_WR:  return int'(wrCount);
      S_PE:  return int'(protErr);
      S_DD:  return int'(drainDone);
      S_UAR: return int'(up_ARREADY);
      S_DAR: return int'(dn_ARVALID);
      S_UAW: return int'(up_AWREADY);
      S_DAW: return int'(dn_AWVALID);
`ifdef CAXI4_TXN_LIMIT_PEAK_EN
      S_RDP: return int'(rdPeak);
      S_WRP: return int'(wrPeak);
`endif
      default: return -1;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    int   act;
    while ((sb.size() > 0) && (sb[0].cyc <= cyc)) begin
      e   = sb.pop_front();
      act = sample(e.sig);
      n_checks++;
      if (act != e.exp) begin
        n_err++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, act, e.exp, cyc);
      end
    end
  end

  task automatic chk(input int sig, input int val, input string nm);
    exp_t e;
    e.cyc  = cyc;
    e.sig  = sig;
    e.exp  = val;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_r(input logic v);
    RVALID = v; RREADY = v; RLAST = v;
  endtask

  task automatic set_b(input logic v);
    BVALID = v; BREADY = v;
  endtask

  initial begin
    sysReset = 1'b1;
    up_ARVALID = 0; dn_ARREADY = 0; up_AWVALID = 0; dn_AWREADY = 0;
    RVALID = 0; RREADY = 0; RLAST = 0; BVALID = 0; BREADY = 0;
    drainReq = 0;
`ifdef CAXI4_TXN_LIMIT_PEAK_EN
    peakClr = 0;
`endif
    repeat (2) @(posedge clk);
    #1 sysReset = 1'b0;

    chk(S_RD, 0, "reset_rdCount");
    chk(S_WR, 0, "reset_wrCount");
    chk(S_PE, 0, "reset_protErr");
    chk(S_DD, 0, "reset_drainDone");
`ifdef CAXI4_TXN_LIMIT_PEAK_EN
    chk(S_RDP, 0, "reset_rdPeak");
    chk(S_WRP, 0, "reset_wrPeak");
`endif

    // Read limit: two issue, third stalls until one RLAST retires
    up_ARVALID = 1; dn_ARREADY = 1;
    chk(S_DAR, 1, "ar_pass_valid");
    chk(S_UAR, 1, "ar_pass_ready");
    step(); chk(S_RD, 1, "ar_count1");
    step(); chk(S_RD, 2, "ar_count_max");
    chk(S_UAR, 0, "ar_block_ready");
    chk(S_DAR, 0, "ar_block_valid");
    set_r(1);
    step(); set_r(0);
    chk(S_RD, 1, "ar_retire_at_max");
    chk(S_UAR, 1, "ar_reopen_ready");
    step(); chk(S_RD, 2, "ar_third_issued");
    up_ARVALID = 0;

    // Simultaneous issue and retire holds the count
    set_r(1);
    step(); set_r(0);
    chk(S_RD, 1, "rd_count_one");
    up_ARVALID = 1; set_r(1);
    step(); up_ARVALID = 0; set_r(0);
    chk(S_RD, 1, "simul_iss_ret_count");
    chk(S_PE, 0, "simul_iss_ret_perr");
    set_r(1);
    step(); set_r(0);
    chk(S_RD, 0, "rd_drained_zero");
    chk(S_PE, 0, "rd_zero_perr");

    // Write completion against an empty counter
    set_b(1);
    step(); set_b(0);
    chk(S_WR, 0, "b_underflow_count");
    chk(S_PE, 1, "b_underflow_perr");
    repeat (10) step();
    chk(S_PE, 1, "perr_sticky");

    // Drain with three writes outstanding
    up_AWVALID = 1; dn_AWREADY = 1;
    repeat (3) step();
    up_AWVALID = 0;
    chk(S_WR, 3, "aw_count3");
    drainReq = 1;
    step();
    up_AWVALID = 1;
    chk(S_DAW, 0, "drain_aw_valid_blocked");
    chk(S_UAW, 0, "drain_aw_ready_blocked");
    chk(S_WR, 3, "drain_count_hold");
    set_b(1);
    step(); chk(S_WR, 2, "drain_b1");
    step(); step(); set_b(0);
    chk(S_WR, 0, "drain_b3");
    chk(S_DD, 0, "drain_not_done");
    step();
    chk(S_DD, 0, "drained_entry_cycle");
    chk(S_DAW, 0, "drained_aw_blocked");
    step();
    chk(S_DD, 1, "drain_done_set");
    drainReq = 0;
    step();
    chk(S_DD, 0, "drain_done_clear");
    chk(S_DAW, 1, "run_aw_released");
    step(); up_AWVALID = 0;
    chk(S_WR, 1, "held_aw_issued");
    set_b(1);
    step(); set_b(0);
    chk(S_WR, 0, "aw_retired");

    // Asynchronous reset mid-cycle
    up_ARVALID = 1; up_AWVALID = 1;
    repeat (5) step();
    up_ARVALID = 0; up_AWVALID = 0;
    chk(S_RD, 2, "pre_reset_rd");
    chk(S_WR, 5, "pre_reset_wr");
    @(posedge clk);
    #2 sysReset = 1'b1;
    chk(S_RD, 0, "async_rst_rd");
    chk(S_WR, 0, "async_rst_wr");
    chk(S_PE, 0, "async_rst_perr");
    chk(S_DD, 0, "async_rst_dd");
    step(); sysReset = 1'b0;
    chk(S_RD, 0, "post_reset_rd");

`ifdef CAXI4_TXN_LIMIT_PEAK_EN
    up_ARVALID = 1; up_AWVALID = 1;
    repeat (4) step();
    up_ARVALID = 0; up_AWVALID = 0;
    chk(S_RD, 2, "peak_rd_count");
    chk(S_WR, 4, "peak_wr_count");
    set_r(1); set_b(1);
    repeat (2) step();
    set_r(0);
    repeat (2) step();
    set_b(0);
    chk(S_RD, 0, "peak_rd_retired");
    chk(S_WR, 0, "peak_wr_retired");
    chk(S_RDP, 2, "rdPeak_held");
    chk(S_WRP, 4, "wrPeak_held");
    chk(S_PE, 0, "peak_no_perr");
    peakClr = 1;
    step(); peakClr = 0;
    chk(S_RDP, 0, "rdPeak_cleared");
    chk(S_WRP, 0, "wrPeak_cleared");
`endif

    for (int i = 0; (i < 10) && (sb.size() > 0); i++) step();
    if (sb.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
